// File: rtl/led_pattern_gen.sv
// led_pattern_gen
// Multi-channel LED driver. Each channel is OFF, ON, BLINK (half-period of
// 2^DIV_W clocks, optional phase inversion) or PWM (duty out of 2^PWM_W).
// A free-running prescaler supplies the blink timebase and a free-running
// counter supplies the PWM ramp. Pin drive is registered and per-channel
// polarity is fixed by ACTIVE_LOW_MASK.

module led_pattern_gen #(
  parameter int                N_LED           = 2,
  parameter int                DIV_W           = 24,
  parameter int                PWM_W           = 8,
  parameter logic [N_LED-1:0]  ACTIVE_LOW_MASK = 2'b10,
  localparam int               CH_W            = (N_LED > 1) ? $clog2(N_LED) : 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              WR_EN,
  input  logic [CH_W-1:0]   WR_CH,
  input  logic [1:0]        WR_MODE,
  input  logic [PWM_W-1:0]  WR_DUTY,
  input  logic              WR_PHASE,
  output logic              BLINK_TICK,
  output logic [N_LED-1:0]  LED
);

  localparam logic [1:0] MODE_OFF   = 2'd0;
  localparam logic [1:0] MODE_ON    = 2'd1;
  localparam logic [1:0] MODE_BLINK = 2'd2;
  localparam logic [1:0] MODE_PWM   = 2'd3;

  // Timebase state
  logic [DIV_W-1:0] clk_div_r;
  logic [PWM_W-1:0] pwm_cnt_r;
  logic             blink_phase_r;

  // Per-channel configuration
  logic [1:0]       mode_r  [N_LED];
  logic [PWM_W-1:0] duty_r  [N_LED];
  logic [N_LED-1:0] phase_r;

  // Output stage
  logic [N_LED-1:0] led_r;

  // Combinational helpers
  logic             blink_tick_s;
  logic [N_LED-1:0] wr_sel_s;
  logic [N_LED-1:0] lit_s;

  // Tick is a pure decode of the prescaler; gated by RST so it can never
  // assert during reset even for prescaler widths where all-ones is reset.
  assign blink_tick_s = ~RST & (&clk_div_r);
  assign BLINK_TICK   = blink_tick_s;
  assign LED          = led_r;

  // Channel write decode: an index with no matching channel selects nothing,
  // so out-of-range writes fall away without a separate range check.
  always_comb begin
    wr_sel_s = '0;
    for (int i = 0; i < N_LED; i++) begin
      wr_sel_s[i] = WR_EN & (WR_CH == CH_W'(i));
    end
  end

  // Prescaler and PWM ramp: free-running, never touched by configuration writes.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      clk_div_r <= '0;
      pwm_cnt_r <= '0;
    end else begin
      clk_div_r <= clk_div_r + DIV_W'(1);
      pwm_cnt_r <= pwm_cnt_r + PWM_W'(1);
    end
  end

  // Blink phase flips on the edge that ends a tick cycle (clock-enable, no derived clock).
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      blink_phase_r <= 1'b0;
    end else if (blink_tick_s) begin
      blink_phase_r <= ~blink_phase_r;
    end else begin
      blink_phase_r <= blink_phase_r;
    end
  end

  // Configuration registers: mode, duty and phase of a channel update together.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < N_LED; i++) begin
        mode_r[i] <= MODE_BLINK;
        duty_r[i] <= '0;
      end
      phase_r <= '0;
    end else begin
      for (int i = 0; i < N_LED; i++) begin
        if (wr_sel_s[i]) begin
          mode_r[i]  <= WR_MODE;
          duty_r[i]  <= WR_DUTY;
          phase_r[i] <= WR_PHASE;
        end else begin
          mode_r[i]  <= mode_r[i];
          duty_r[i]  <= duty_r[i];
          phase_r[i] <= phase_r[i];
        end
      end
    end
  end

  // Per-channel "lit" decision from the current state registers.
  always_comb begin
    lit_s = '0;
    for (int i = 0; i < N_LED; i++) begin
      case (mode_r[i])
        MODE_OFF:   lit_s[i] = 1'b0;
        MODE_ON:    lit_s[i] = 1'b1;
        MODE_BLINK: lit_s[i] = blink_phase_r ^ phase_r[i];
        MODE_PWM:   lit_s[i] = (pwm_cnt_r < duty_r[i]);
        default:    lit_s[i] = 1'b0;
      endcase
    end
  end

  // Registered pin drive with per-channel polarity; reset leaves every LED unlit.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      led_r <= ACTIVE_LOW_MASK;
    end else begin
      led_r <= lit_s ^ ACTIVE_LOW_MASK;
    end
  end

endmodule

// File: tb/tb_led_pattern_gen.sv
// Directed testbench for led_pattern_gen with a reference model feeding a
// scoreboard queue of expected LED values, plus hand-derived directed checks.

module tb_led_pattern_gen;

  localparam int         N_LED = 3;
  localparam int         DIV_W = 4;
  localparam int         PWM_W = 3;
  localparam logic [2:0] MASK  = 3'b010;

  logic       CLK = 1'b0;
  logic       RST;
  logic       WR_EN;
  logic [1:0] WR_CH;
  logic [1:0] WR_MODE;
  logic [2:0] WR_DUTY;
  logic       WR_PHASE;
  logic       BLINK_TICK;
  logic [2:0] LED;

  led_pattern_gen #(
    .N_LED(N_LED),
    .DIV_W(DIV_W),
    .PWM_W(PWM_W),
    .ACTIVE_LOW_MASK(MASK)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .WR_EN(WR_EN),
    .WR_CH(WR_CH),
    .WR_MODE(WR_MODE),
    .WR_DUTY(WR_DUTY),
    .WR_PHASE(WR_PHASE),
    .BLINK_TICK(BLINK_TICK),
    .LED(LED)
  );

  always #5 CLK = ~CLK;

  int tests = 0;
  int fails = 0;

  // Reference model state
  logic [3:0] m_div;
  logic [2:0] m_pwm;
  logic       m_phase;
  logic [1:0] m_mode [3];
  logic [2:0] m_duty [3];
  logic [2:0] m_ph;

  logic [2:0] exp_q [$];
  logic [2:0] last_led;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_div   = 4'd0;
    m_pwm   = 3'd0;
    m_phase = 1'b0;
    m_ph    = 3'b000;
    for (int i = 0; i < 3; i++) begin
      m_mode[i] = 2'd2;
      m_duty[i] = 3'd0;
    end
  endtask

  function automatic logic [2:0] m_lit();
    logic [2:0] l;
    l = 3'b000;
    for (int i = 0; i < 3; i++) begin
      case (m_mode[i])
        2'd0:    l[i] = 1'b0;
        2'd1:    l[i] = 1'b1;
        2'd2:    l[i] = m_phase ^ m_ph[i];
        default: l[i] = (m_pwm < m_duty[i]);
      endcase
    end
    return l;
  endfunction

  // Model of one rising edge, using the inputs currently driven.
  task automatic m_edge();
    if (m_div == 4'hF) m_phase = ~m_phase;
    if (WR_EN && (WR_CH < 2'd3)) begin
      m_mode[WR_CH] = WR_MODE;
      m_duty[WR_CH] = WR_DUTY;
      m_ph[WR_CH]   = WR_PHASE;
    end
    m_div = m_div + 4'd1;
    m_pwm = m_pwm + 3'd1;
  endtask

  // One clock cycle: check tick, push expected LED, take the edge, pop and compare.
  task automatic step();
    logic [2:0] e;
    chk("tick_sb", {31'd0, BLINK_TICK}, {31'd0, (m_div == 4'hF)});
    exp_q.push_back(m_lit() ^ MASK);
    @(posedge CLK);
    m_edge();
    #1;
    last_led = LED;
    e = exp_q.pop_front();
    chk("led_sb", {29'd0, LED}, {29'd0, e});
    @(negedge CLK);
  endtask

  task automatic write(input logic [1:0] ch, input logic [1:0] mode,
                       input logic [2:0] duty, input logic ph);
    WR_EN    = 1'b1;
    WR_CH    = ch;
    WR_MODE  = mode;
    WR_DUTY  = duty;
    WR_PHASE = ph;
    step();
    WR_EN    = 1'b0;
  endtask

  task automatic count_led0(output int cnt);
    cnt = 0;
    for (int k = 0; k < 8; k++) begin
      step();
      if (last_led[0]) cnt++;
    end
  endtask

  initial begin
    int         first_tick;
    int         cnt;
    logic [2:0] led16, led17, led32, led33;
    logic       exp0;

    RST = 1'b1; WR_EN = 1'b0; WR_CH = 2'd0; WR_MODE = 2'd0; WR_DUTY = 3'd0; WR_PHASE = 1'b0;
    m_reset();
    led16 = 3'b000; led17 = 3'b000; led32 = 3'b000; led33 = 3'b000;
    repeat (2) @(negedge CLK);
    chk("rst_led", {29'd0, LED}, 32'h2);
    chk("rst_tick", {31'd0, BLINK_TICK}, 32'h0);

    // Defaults after release: unlit 16 edges, then alternate every 16
    RST = 1'b0;
    first_tick = 0;
    for (int c = 1; c <= 40; c++) begin
      if (BLINK_TICK && (first_tick == 0)) first_tick = c;
      step();
      if (c == 16) led16 = last_led;
      if (c == 17) led17 = last_led;
      if (c == 32) led32 = last_led;
      if (c == 33) led33 = last_led;
    end
    chk("first_tick", first_tick, 16);
    chk("dflt_e16", {29'd0, led16}, 32'h2);
    chk("dflt_e17", {29'd0, led17}, 32'h5);
    chk("dflt_e32", {29'd0, led32}, 32'h5);
    chk("dflt_e33", {29'd0, led33}, 32'h2);

    // PWM on channel 0
    write(2'd0, 2'd3, 3'd3, 1'b0);
    step();
    count_led0(cnt);
    chk("pwm_duty3", cnt, 3);
    write(2'd0, 2'd3, 3'd0, 1'b0);
    step();
    count_led0(cnt);
    chk("pwm_duty0", cnt, 0);
    write(2'd0, 2'd3, 3'd7, 1'b0);
    step();
    count_led0(cnt);
    chk("pwm_duty7", cnt, 7);

    // ON / OFF and out-of-range write
    write(2'd1, 2'd1, 3'd0, 1'b0);
    write(2'd2, 2'd0, 3'd0, 1'b0);
    chk("on_ch1", {31'd0, last_led[1]}, 32'h0);
    step();
    chk("off_ch2", {31'd0, last_led[2]}, 32'h0);
    write(2'd3, 2'd1, 3'd5, 1'b1);
    repeat (3) step();
    chk("ign_ch1", {31'd0, last_led[1]}, 32'h0);
    chk("ign_ch2", {31'd0, last_led[2]}, 32'h0);
    count_led0(cnt);
    chk("ign_ch0", cnt, 7);

    // Write coinciding with a blink tick
    for (int k = 0; (k < 20) && (m_div != 4'hF); k++) step();
    chk("tick_wr_cycle", {31'd0, BLINK_TICK}, 32'h1);
    write(2'd0, 2'd2, 3'd0, 1'b1);
    exp0 = m_phase ^ 1'b1;
    step();
    chk("blink_wr_next", {31'd0, last_led[0]}, {31'd0, exp0});
    repeat (15) step();
    chk("blink_wr_hold", {31'd0, last_led[0]}, {31'd0, exp0});
    step();
    chk("blink_wr_flip", {31'd0, last_led[0]}, {31'd0, ~exp0});

    // Asynchronous reset mid-run with a write in flight
    WR_EN = 1'b1; WR_CH = 2'd1; WR_MODE = 2'd0; WR_DUTY = 3'd0; WR_PHASE = 1'b0;
    #2;
    RST = 1'b1;
    #1;
    chk("async_rst_led", {29'd0, LED}, 32'h2);
    chk("async_rst_tick", {31'd0, BLINK_TICK}, 32'h0);
    @(posedge CLK);
    #1;
    chk("rst_hold_led", {29'd0, LED}, 32'h2);
    @(negedge CLK);
    WR_EN = 1'b0;
    RST = 1'b0;
    m_reset();
    exp_q.delete();
    first_tick = 0;
    for (int c = 1; c <= 20; c++) begin
      if (BLINK_TICK && (first_tick == 0)) first_tick = c;
      step();
      if (c == 16) led16 = last_led;
      if (c == 17) led17 = last_led;
    end
    chk("rerun_first_tick", first_tick, 16);
    chk("rerun_e16", {29'd0, led16}, 32'h2);
    chk("rerun_e17", {29'd0, led17}, 32'h5);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/led_pattern_gen.md
LED_PATTERN_GEN -- requirements
Module: led_pattern_gen

Interface
REQ-001 SHALL have parameter N_LED, default 2, number of LED channels (1..16).
REQ-002 SHALL have parameter DIV_W, default 24, width of the blink prescaler; blink half-period is 2^DIV_W CLK cycles.
REQ-003 SHALL have parameter PWM_W, default 8, width of the PWM counter and of each channel's duty value.
REQ-004 SHALL have parameter ACTIVE_LOW_MASK, default 2'b10 (width N_LED); a set bit marks an inverted, active-low output.
REQ-005 SHALL have port CLK  input  1  single system clock; all state changes on its rising edge.
REQ-006 SHALL have port RST  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port WR_EN  input  1  configuration write strobe.
REQ-008 SHALL have port WR_CH  input  CH_W = max(1, clog2(N_LED))  channel index written.
REQ-009 SHALL have port WR_MODE  input  2  mode: 0 OFF, 1 ON, 2 BLINK, 3 PWM.
REQ-010 SHALL have port WR_DUTY  input  PWM_W  PWM duty value.
REQ-011 SHALL have port WR_PHASE  input  1  blink phase-invert bit.
REQ-012 SHALL have port BLINK_TICK  output  1  one-cycle pulse marking prescaler wrap.
REQ-013 SHALL have port LED  output  N_LED  registered LED pin drive.

Function
REQ-014 SHALL increment prescaler clk_div (DIV_W bits) by 1 every CLK, wrapping from all-ones to 0.
REQ-015 SHALL drive BLINK_TICK high exactly in cycles where clk_div is all-ones, decoded from the register, no extra flop.
REQ-016 SHALL toggle blink_phase on the CLK edge where BLINK_TICK is high; it SHALL NOT use a derived clock.
REQ-017 SHALL increment pwm_cnt (PWM_W bits) by 1 every CLK, free-running and wrapping.
REQ-018 SHALL hold per-channel mode (2b), duty (PWM_W b) and phase (1b) registers.
REQ-019 SHALL compute channel i "lit": OFF 0; ON 1; BLINK blink_phase XOR phase[i]; PWM (pwm_cnt < duty[i]), unsigned compare.
REQ-020 SHALL make PWM duty 0 never lit and duty 2^PWM_W-1 lit for 2^PWM_W-1 of every 2^PWM_W cycles.
REQ-021 SHALL register LED[i] <= lit_i XOR ACTIVE_LOW_MASK[i], giving one-cycle latency from state registers to pin.
REQ-022 SHALL write WR_MODE, WR_DUTY and WR_PHASE into channel WR_CH on a CLK edge with WR_EN high, updating all three fields together.
REQ-023 SHALL show a written config on LED at the edge after the write edge.
REQ-024 SHALL ignore writes with WR_CH >= N_LED, changing no state.
REQ-025 SHALL, for a write in a BLINK_TICK cycle, apply both the write and the blink_phase toggle at that edge; the next LED value uses both new values.
REQ-026 SHALL keep prescaler and PWM counter free-running and unaffected by writes.

Reset
REQ-027 SHALL, while RST is high, immediately (without CLK) force clk_div=0, pwm_cnt=0, blink_phase=0, all modes=BLINK, duties=0, phases=0, LED=ACTIVE_LOW_MASK (all unlit).
REQ-028 SHALL hold BLINK_TICK low while RST is high, including when DIV_W-bit all-ones is unreachable.
REQ-029 SHALL, on RST assertion mid-operation, discard any in-flight write and restart all counters from 0 on release.
REQ-030 SHALL, after release, keep default-configured channels unlit until the first BLINK_TICK, then lit for 2^DIV_W cycles, then alternate.

Verification
Bench uses N_LED=3, DIV_W=4, PWM_W=3, ACTIVE_LOW_MASK=3'b010.
REQ-031 SHALL check: RST pulsed mid-run, no CLK edge -> LED=3'b010, BLINK_TICK=0 at once; after release, first BLINK_TICK in 16th cycle.
REQ-032 SHALL check: defaults after release -> LED=3'b010 for 16 edges, then 3'b101 one edge after first tick, toggling every 16 cycles.
REQ-033 SHALL check: write ch0 PWM duty 3 -> LED[0] high exactly 3 of every 8 cycles; duty 0 -> LED[0] constantly 0; duty 7 -> high 7 of 8.
REQ-034 SHALL check: write ch1 ON, ch2 OFF -> LED[1]=0, LED[2]=0 one edge after the write; WR_CH=3 write -> no LED or config change.
REQ-035 SHALL check: write ch0 BLINK phase 1 in a BLINK_TICK cycle -> next LED[0] = new blink_phase XOR 1, and continued alternation matches.
